bicubic_tile_serializer: RTL and testbench
==========================================

// Module: bicubic_tile_serializer
// PURPOSE
//  Consumer stage after the bicubic upsample core. Collects the four 4-pixel response
//  beats of one upsampled 4x4 tile (beat k = output row k) into a ping-pong tile buffer.
//  Replays each tile one pixel per cycle in row-major order, with row/tile markers, to
//  the output writer. Double buffering lets the core fill tile N+1 while tile N drains.
// PARAMETERS
//  CHANNEL_WIDTH   8   bits per pixel channel; matches the upsample core output width
// PORTS
//  clk             in   1              system clock
//  rst_n           in   1              asynchronous active-low reset
//  bcci_rsp_valid  in   1              upsample core response beat valid
//  bcci_rsp_data1  in   CHANNEL_WIDTH  beat pixel column 0
//  bcci_rsp_data2  in   CHANNEL_WIDTH  beat pixel column 1
//  bcci_rsp_data3  in   CHANNEL_WIDTH  beat pixel column 2
//  bcci_rsp_data4  in   CHANNEL_WIDTH  beat pixel column 3
//  bf_rsp_ready    out  1              this block accepts a beat
//  ts_out_valid    out  1              serial pixel valid
//  ts_out_data     out  CHANNEL_WIDTH  serial pixel
//  ts_out_row_last out  1              pixel is column 3 of its row
//  ts_out_tile_last out 1              pixel is row 3 / column 3 (16th of tile)
//  ts_out_ready    in   1              downstream accepts pixel
//  ts_busy         out  1              any buffer full or partially written
// BEHAVIOUR
//  - Storage: buf[2][4 rows][4 cols] x CHANNEL_WIDTH; full[1:0] flags; wr_sel, rd_sel (1b).
//  - Counters: wr_row 2b (rows written into buf[wr_sel]); rd_idx 4b (row=rd_idx[3:2], col=rd_idx[1:0]).
//  - Reset (async): full=2'b00, wr_sel=0, rd_sel=0, wr_row=0, rd_idx=0. Buffer contents not reset.
//    Outputs after reset: bf_rsp_ready=1, ts_out_valid=0, row_last=0, tile_last=0, busy=0;
//    ts_out_data don't-care while invalid.
//  - Input handshake: in_hs = bcci_rsp_valid & bf_rsp_ready. bf_rsp_ready = ~full[wr_sel] (comb.).
//    On in_hs: buf[wr_sel][wr_row] <= {data4,data3,data2,data1}; wr_row++.
//    When in_hs and wr_row==3: full[wr_sel]<=1, wr_sel toggles, wr_row wraps to 0.
//  - Output handshake: out_hs = ts_out_valid & ts_out_ready.
//    ts_out_valid = full[rd_sel] (comb.); ts_out_data = buf[rd_sel][rd_idx[3:2]][rd_idx[1:0]].
//    ts_out_row_last = valid & (rd_idx[1:0]==3); ts_out_tile_last = valid & (rd_idx==15).
//    On out_hs: rd_idx++; at rd_idx==15: full[rd_sel]<=0, rd_sel toggles, rd_idx wraps to 0.
//  - Valid/data held stable while ts_out_ready=0 (no pixel dropped or repeated).
//  - Latency: 4th beat accepted at edge T -> ts_out_valid=1 in cycle after T (1 cycle),
//    provided the read side was idle.
//  - Throughput: 4 input cycles + 16 output cycles per tile; input stalls only when both full.
//  - Simultaneous events: tile write completion and tile read completion in the same cycle
//    each update only their own full bit (set and clear address different buffers by
//    construction); both take effect.
//  - Both full: bf_rsp_ready=0 until first out_hs on tile_last frees buf[rd_sel]; ready
//    returns the following cycle.
//  - A partially written tile (wr_row!=0) is never presented to output.
//  - ts_busy = |full | (wr_row!=0).
//  - Reset asserted mid-tile: all partial and full tiles discarded; outputs return to reset values.
// TESTING
//  1 Reset: rst_n=0 mid-cycle -> immediately ready=1, out_valid=0, busy=0, no clk needed.
//  2 Single tile: beats rows {r*16+c} for r,c=0..3, out_ready=1 -> 16 pixels 0x00,0x01,..,0x33
//    row-major (values 16r+c); row_last on idx 3,7,11,15; tile_last only on 16th; first
//    valid 1 cycle after 4th beat.
//  3 Backpressure: out_ready toggles 1,0 every cycle -> same 16-value sequence, data stable
//    while stalled, 32 cycles drain.
//  4 Double buffer: 3 tiles back-to-back, out_ready=0 -> ready drops after 8th beat; raise
//    out_ready -> ready reasserts cycle after 16th pixel, tiles emerge in order 0,1,2.
//  5 Simultaneous: 4th beat of tile B accepted same edge as tile A's tile_last handshake ->
//    next cycle full=B only, valid=1, data=B[0][0].
//  6 Reset mid-op: 2 beats written, reset, 4 new beats -> output only the new tile, busy=0 after.

Source files
------------

// File: rtl/bicubic_tile_serializer_if.sv
// Bus bundle between the bicubic upsample core, the tile serializer and the
// output writer. The slave modport is the serializer's view.
interface bicubic_tile_serializer_if #(
  parameter int CHANNEL_WIDTH = 8
);
  // beat input from the upsample core (one output row of the 4x4 tile per beat)
  logic                     bcci_rsp_valid;
  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data1;
  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data2;
  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data3;
  logic [CHANNEL_WIDTH-1:0] bcci_rsp_data4;
  logic                     bf_rsp_ready;
  // serial pixel output to the writer
  logic                     ts_out_valid;
  logic [CHANNEL_WIDTH-1:0] ts_out_data;
  logic                     ts_out_row_last;
  logic                     ts_out_tile_last;
  logic                     ts_out_ready;
  logic                     ts_busy;

  modport master (
    output bcci_rsp_valid, bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4,
    input  bf_rsp_ready,
    input  ts_out_valid, ts_out_data, ts_out_row_last, ts_out_tile_last, ts_busy,
    output ts_out_ready
  );

  modport slave (
    input  bcci_rsp_valid, bcci_rsp_data1, bcci_rsp_data2, bcci_rsp_data3, bcci_rsp_data4,
    output bf_rsp_ready,
    output ts_out_valid, ts_out_data, ts_out_row_last, ts_out_tile_last, ts_busy,
    input  ts_out_ready
  );
endinterface

// File: rtl/bicubic_tile_serializer.sv
// Ping-pong 4x4 tile buffer: collects four row beats from the bicubic core into
// one half while the other half replays its 16 pixels row-major to the writer.
// A half is only presented once all four rows are in, and only refilled once
// its 16th pixel has been handed off.
module bicubic_tile_serializer #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bicubic_tile_serializer_if.slave  bus
);
  localparam int NUM_LANES = 4;

  // storage and control state
  logic [CHANNEL_WIDTH-1:0]                r_buf [2][4][NUM_LANES];
  logic [1:0]                              r_full;
  logic                                    r_wr_sel;
  logic                                    r_rd_sel;
  logic [1:0]                              r_wr_row;
  logic [3:0]                              r_rd_idx;

  logic [NUM_LANES-1:0][CHANNEL_WIDTH-1:0] w_beat;
  logic                                    w_in_hs;
  logic                                    w_out_hs;
  logic                                    w_wr_done;
  logic                                    w_rd_done;
  logic                                    w_valid;
  logic [1:0]                              w_full_nxt;

  assign w_beat    = {bus.bcci_rsp_data4, bus.bcci_rsp_data3,
                      bus.bcci_rsp_data2, bus.bcci_rsp_data1};
  assign w_in_hs   = bus.bcci_rsp_valid & ~r_full[r_wr_sel];
  assign w_valid   = r_full[r_rd_sel];
  assign w_out_hs  = w_valid & bus.ts_out_ready;
  assign w_wr_done = w_in_hs & (r_wr_row == 2'd3);
  assign w_rd_done = w_out_hs & (r_rd_idx == 4'd15);

  // Set and clear always target different halves (write half is never full,
  // read half always is), so both may land on the same edge.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_rd_done) w_full_nxt[r_rd_sel] = 1'b0;
  end

  // tile data is never reset; the full flags gate every read
  always_ff @(posedge clk) begin
    if (w_in_hs)
      for (int l = 0; l < NUM_LANES; l++)
        r_buf[r_wr_sel][r_wr_row][l] <= w_beat[l];
  end

  // write/read pointers and occupancy; reset discards any partial or full tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full   <= 2'b00;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_row <= 2'd0;
      r_rd_idx <= 4'd0;
    end else begin
      r_full <= w_full_nxt;
      if (w_in_hs) begin
        r_wr_row <= r_wr_row + 2'd1;
        if (w_wr_done) r_wr_sel <= ~r_wr_sel;
      end
      if (w_out_hs) begin
        r_rd_idx <= r_rd_idx + 4'd1;
        if (w_rd_done) r_rd_sel <= ~r_rd_sel;
      end
    end
  end

  assign bus.bf_rsp_ready     = ~r_full[r_wr_sel];
  assign bus.ts_out_valid     = w_valid;
  assign bus.ts_out_data      = r_buf[r_rd_sel][r_rd_idx[3:2]][r_rd_idx[1:0]];
  assign bus.ts_out_row_last  = w_valid & (r_rd_idx[1:0] == 2'd3);
  assign bus.ts_out_tile_last = w_valid & (r_rd_idx == 4'd15);
  assign bus.ts_busy          = (|r_full) | (r_wr_row != 2'd0);
endmodule

// File: tb/tb_bicubic_tile_serializer.sv
// Directed bench for the tile serializer. Tile pixel (r,c) carries base+16r+c,
// so every expected output value is computed from the tile base alone.
module tb_bicubic_tile_serializer;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  bicubic_tile_serializer_if #(.CHANNEL_WIDTH(8)) bus();

  bicubic_tile_serializer #(.CHANNEL_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // capture of every accepted pixel, plus stability check while stalled
  logic [7:0] q_d[$];
  bit         q_rl[$];
  bit         q_tl[$];
  int         q_c[$];
  bit         hold_chk = 0;
  logic [7:0] hold_d;

  always @(negedge clk) begin
    if (hold_chk) begin
      chk("hold_valid", bus.ts_out_valid, 1);
      chk("hold_data", bus.ts_out_data, hold_d);
    end
    hold_chk = rst_n && bus.ts_out_valid && !bus.ts_out_ready;
    hold_d   = bus.ts_out_data;
    if (rst_n && bus.ts_out_valid && bus.ts_out_ready) begin
      q_d.push_back(bus.ts_out_data);
      q_rl.push_back(bus.ts_out_row_last);
      q_tl.push_back(bus.ts_out_tile_last);
      q_c.push_back(cyc);
    end
  end

  // one row beat: columns base..base+3; returns just after the accepting edge
  task automatic send_beat(input logic [7:0] b);
    int to = 0;
    bus.bcci_rsp_valid = 1'b1;
    bus.bcci_rsp_data1 = b;
    bus.bcci_rsp_data2 = b + 8'd1;
    bus.bcci_rsp_data3 = b + 8'd2;
    bus.bcci_rsp_data4 = b + 8'd3;
    forever begin
      @(negedge clk);
      if (bus.bf_rsp_ready) break;
      if (++to > 300) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1 bus.bcci_rsp_valid = 1'b0;
  endtask

  task automatic send_tile(input logic [7:0] base);
    for (int r = 0; r < 4; r++) send_beat(base + 8'(16 * r));
  endtask

  task automatic wait_px(input int n);
    int k;
    for (k = 0; k < 500; k++) begin
      @(posedge clk);
      #2;
      if (q_d.size() >= n) break;
    end
    if (k == 500) chk("px_timeout", q_d.size(), n);
  endtask

  task automatic chk_tile(input int off, input logic [7:0] base, input string tag);
    for (int i = 0; i < 16; i++) begin
      if (off + i >= q_d.size()) begin
        chk($sformatf("%s_missing%0d", tag, i), q_d.size(), off + 16);
        break;
      end
      chk($sformatf("%s_d%0d", tag, i), q_d[off+i], base + 8'(16 * (i / 4) + (i % 4)));
      chk($sformatf("%s_rl%0d", tag, i), q_rl[off+i], (i % 4) == 3);
      chk($sformatf("%s_tl%0d", tag, i), q_tl[off+i], i == 15);
    end
  endtask

  initial begin
    bit early;
    rst_n = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    bus.bcci_rsp_data1 = '0;
    bus.bcci_rsp_data2 = '0;
    bus.bcci_rsp_data3 = '0;
    bus.bcci_rsp_data4 = '0;
    bus.ts_out_ready = 1'b0;

    // reset values, no clock edge yet
    #3;
    chk("rst_ready", bus.bf_rsp_ready, 1);
    chk("rst_valid", bus.ts_out_valid, 0);
    chk("rst_busy", bus.ts_busy, 0);
    chk("rst_rl", bus.ts_out_row_last, 0);
    chk("rst_tl", bus.ts_out_tile_last, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // single tile, free-flowing output
    bus.ts_out_ready = 1'b1;
    send_beat(8'h00); send_beat(8'h10); send_beat(8'h20);
    @(negedge clk);
    chk("t2_partial_valid", bus.ts_out_valid, 0);
    chk("t2_partial_busy", bus.ts_busy, 1);
    @(posedge clk); #1;
    send_beat(8'h30);
    @(negedge clk);
    chk("t2_latency", bus.ts_out_valid, 1);
    wait_px(16);
    chk_tile(0, 8'h00, "t2");
    chk("t2_done_valid", bus.ts_out_valid, 0);
    chk("t2_done_busy", bus.ts_busy, 0);

    // backpressure: ready toggles every cycle
    bus.ts_out_ready = 1'b0;
    q_d.delete(); q_rl.delete(); q_tl.delete(); q_c.delete();
    send_tile(8'h80);
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          bus.ts_out_ready = (k % 2 == 0);
          @(posedge clk); #1;
        end
        bus.ts_out_ready = 1'b0;
      end
      wait_px(16);
    join
    chk_tile(0, 8'h80, "t3");
    if (q_c.size() >= 16) chk("t3_span", 32'(q_c[15] - q_c[0]), 30);
    chk("t3_done_busy", bus.ts_busy, 0);

    // double buffering: three tiles with output stalled
    q_d.delete(); q_rl.delete(); q_tl.delete(); q_c.delete();
    send_tile(8'h00);
    send_tile(8'h40);
    @(negedge clk);
    chk("t4_both_full_ready", bus.bf_rsp_ready, 0);
    chk("t4_both_full_valid", bus.ts_out_valid, 1);
    chk("t4_both_full_data", bus.ts_out_data, 8'h00);
    chk("t4_both_full_busy", bus.ts_busy, 1);
    @(posedge clk); #1;
    fork
      send_tile(8'h80);
      begin
        bus.ts_out_ready = 1'b1;
        early = 0;
        for (int k = 0; k < 200; k++) begin
          @(posedge clk); #2;
          if (q_d.size() >= 16) break;
          if (bus.bf_rsp_ready) early = 1;
        end
        chk("t4_ready_early", early, 0);
        chk("t4_ready_back", bus.bf_rsp_ready, 1);
      end
    join
    wait_px(48);
    chk_tile(0, 8'h00, "t4a");
    chk_tile(16, 8'h40, "t4b");
    chk_tile(32, 8'h80, "t4c");
    @(posedge clk); #1;
    bus.ts_out_ready = 1'b0;

    // tile A's last handoff coincides with tile B's last beat
    q_d.delete(); q_rl.delete(); q_tl.delete(); q_c.delete();
    send_tile(8'h08);
    send_beat(8'h48); send_beat(8'h58); send_beat(8'h68);
    bus.ts_out_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    bus.ts_out_ready = 1'b0;
    bus.bcci_rsp_valid = 1'b1;
    bus.bcci_rsp_data1 = 8'h78;
    bus.bcci_rsp_data2 = 8'h79;
    bus.bcci_rsp_data3 = 8'h7a;
    bus.bcci_rsp_data4 = 8'h7b;
    bus.ts_out_ready = 1'b1;
    @(negedge clk);
    chk("t5_pre_tl", bus.ts_out_tile_last, 1);
    chk("t5_pre_ready", bus.bf_rsp_ready, 1);
    @(posedge clk); #1;
    bus.bcci_rsp_valid = 1'b0;
    bus.ts_out_ready = 1'b0;
    @(negedge clk);
    chk("t5_valid", bus.ts_out_valid, 1);
    chk("t5_data", bus.ts_out_data, 8'h48);
    chk("t5_ready", bus.bf_rsp_ready, 1);
    chk("t5_busy", bus.ts_busy, 1);
    chk("t5_tl", bus.ts_out_tile_last, 0);
    @(posedge clk); #1;
    bus.ts_out_ready = 1'b1;
    wait_px(32);
    chk_tile(0, 8'h08, "t5a");
    chk_tile(16, 8'h48, "t5b");
    chk("t5_done_busy", bus.ts_busy, 0);
    bus.ts_out_ready = 1'b0;

    // reset with a half-written tile
    send_beat(8'hc0); send_beat(8'hd0);
    @(negedge clk);
    chk("t6_pre_busy", bus.ts_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", bus.bf_rsp_ready, 1);
    chk("t6_rst_valid", bus.ts_out_valid, 0);
    chk("t6_rst_busy", bus.ts_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    q_d.delete(); q_rl.delete(); q_tl.delete(); q_c.delete();
    bus.ts_out_ready = 1'b1;
    send_tile(8'h04);
    wait_px(16);
    chk_tile(0, 8'h04, "t6");
    chk("t6_done_busy", bus.ts_busy, 0);
    repeat (6) @(posedge clk);
    #2;
    chk("t6_no_extra", q_d.size(), 16);
    chk("t6_idle_valid", bus.ts_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // hard stop in case a handshake never completes
  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
